// File: rtl/filter_bank_sequencer.sv
// Frame sequencer for the 13-channel note filter bank: accepts one sample per frame,
// walks every tap through the sample buffer and coefficient ROM, then latches the sums.
module filter_bank_sequencer #(
  parameter int NUM_TAPS = 174,
  parameter int TAP_AW   = 8,
  parameter int BUF_AW   = 8,
  parameter int ROM_LAT  = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sample_valid,
  input  logic [31:0]       sample_in,
  output logic              sample_ready,
  output logic              buf_wr_en,
  output logic [BUF_AW-1:0] buf_wr_addr,
  output logic [31:0]       buf_wr_data,
  output logic [BUF_AW-1:0] buf_rd_addr,
  output logic [TAP_AW-1:0] coeff_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              mask_zero,
  output logic              result_latch,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_LATCH} state_t;

  localparam int                FILL_W     = $clog2(NUM_TAPS + 1);
  localparam logic [TAP_AW-1:0] TAP_LAST   = TAP_AW'(NUM_TAPS - 1);
  localparam logic [FILL_W-1:0] FILL_MAX   = FILL_W'(NUM_TAPS);
  localparam logic [1:0]        DRAIN_LAST = 2'((ROM_LAT > 0) ? (ROM_LAT - 1) : 0);

  state_t              state_q, state_d;
  logic [BUF_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [BUF_AW-1:0]   base_q, base_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [TAP_AW-1:0]   tap_q, tap_d;
  logic [1:0]          drain_q, drain_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [TAP_AW-1:0]   coeff_hold_q, coeff_hold_d;
  logic [BUF_AW-1:0]   rd_hold_q, rd_hold_d;

  logic                accept_s;
  logic                issue_s;
  logic                mask_s;
  logic                latch_s;
  logic [BUF_AW-1:0]   rd_addr_s;
  logic                pipe_en_s;
  logic                pipe_mask_s;

  // Tap k reads sample n-k, which only exists once fill > k.
  assign rd_addr_s = base_q - BUF_AW'(tap_q);
  assign mask_s    = (32'(tap_q) >= 32'(fill_q));

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    base_d       = base_q;
    fill_d       = fill_q;
    tap_d        = tap_q;
    drain_d      = drain_q;
    frame_cnt_d  = frame_cnt_q;
    coeff_hold_d = coeff_hold_q;
    rd_hold_d    = rd_hold_q;
    accept_s     = 1'b0;
    issue_s      = 1'b0;
    latch_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sample_valid) begin
          accept_s = 1'b1;
          base_d   = wr_ptr_q;
          wr_ptr_d = wr_ptr_q + BUF_AW'(1);
          fill_d   = (fill_q < FILL_MAX) ? (fill_q + FILL_W'(1)) : fill_q;
          tap_d    = '0;
          state_d  = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        issue_s      = 1'b1;
        coeff_hold_d = tap_q;
        rd_hold_d    = rd_addr_s;
        tap_d        = tap_q + TAP_AW'(1);
        drain_d      = 2'd0;
        if (tap_q == TAP_LAST) begin
          state_d = (ROM_LAT > 0) ? S_DRAIN : S_LATCH;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_LATCH;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      S_LATCH: begin
        latch_s     = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      base_q       <= '0;
      fill_q       <= '0;
      tap_q        <= '0;
      drain_q      <= 2'd0;
      frame_cnt_q  <= 16'd0;
      coeff_hold_q <= '0;
      rd_hold_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      base_q       <= base_d;
      fill_q       <= fill_d;
      tap_q        <= tap_d;
      drain_q      <= drain_d;
      frame_cnt_q  <= frame_cnt_d;
      coeff_hold_q <= coeff_hold_d;
      rd_hold_q    <= rd_hold_d;
    end
  end

  // Issue/mask pair delayed to line up with the products reaching the accumulators.
  if (ROM_LAT == 0) begin : g_nolat
    assign pipe_en_s   = issue_s;
    assign pipe_mask_s = mask_s;
  end else begin : g_lat
    logic [ROM_LAT-1:0] en_pipe_q, en_pipe_d;
    logic [ROM_LAT-1:0] mask_pipe_q, mask_pipe_d;

    always_comb begin
      en_pipe_d      = en_pipe_q << 1;
      en_pipe_d[0]   = issue_s;
      mask_pipe_d    = mask_pipe_q << 1;
      mask_pipe_d[0] = mask_s;
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        en_pipe_q   <= '0;
        mask_pipe_q <= '0;
      end else begin
        en_pipe_q   <= en_pipe_d;
        mask_pipe_q <= mask_pipe_d;
      end
    end

    assign pipe_en_s   = en_pipe_q[ROM_LAT-1];
    assign pipe_mask_s = mask_pipe_q[ROM_LAT-1];
  end

  assign sample_ready = resetn & (state_q == S_IDLE);
  assign buf_wr_en    = resetn & accept_s;
  assign acc_clr      = resetn & accept_s;
  assign buf_wr_addr  = resetn ? wr_ptr_q : '0;
  assign buf_wr_data  = resetn ? sample_in : 32'd0;
  assign buf_rd_addr  = !resetn ? '0 : (issue_s ? rd_addr_s : rd_hold_q);
  assign coeff_addr   = !resetn ? '0 : (issue_s ? tap_q : coeff_hold_q);
  assign acc_en       = resetn & pipe_en_s;
  assign mask_zero    = resetn & pipe_en_s & pipe_mask_s;
  assign result_latch = resetn & latch_s;
  assign frame_cnt    = resetn ? frame_cnt_q : 16'd0;

endmodule

// File: tb/tb_filter_bank_sequencer.sv
// Bench for filter_bank_sequencer: three instances (ROM_LAT 1, 0, 2) checked each cycle
// against a frame-phase model, plus literal pins on windows, masks and periods.
module tb_filter_bank_sequencer;

  localparam int N = 174;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_r [3];
  logic [31:0] data_r  [3];

  logic        ready_w  [3];
  logic        wr_en_w  [3];
  logic [7:0]  wr_addr_w[3];
  logic [31:0] wr_data_w[3];
  logic [7:0]  rd_w     [3];
  logic [7:0]  coeff_w  [3];
  logic        clr_w    [3];
  logic        en_w     [3];
  logic        mask_w   [3];
  logic        latch_w  [3];
  logic [15:0] fc_w     [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    filter_bank_sequencer #(
      .NUM_TAPS(174), .TAP_AW(8), .BUF_AW(8),
      .ROM_LAT((g == 0) ? 1 : ((g == 1) ? 0 : 2))
    ) u_dut (
      .clk(clk), .resetn(resetn),
      .sample_valid(valid_r[g]), .sample_in(data_r[g]),
      .sample_ready(ready_w[g]), .buf_wr_en(wr_en_w[g]),
      .buf_wr_addr(wr_addr_w[g]), .buf_wr_data(wr_data_w[g]),
      .buf_rd_addr(rd_w[g]), .coeff_addr(coeff_w[g]),
      .acc_clr(clr_w[g]), .acc_en(en_w[g]), .mask_zero(mask_w[g]),
      .result_latch(latch_w[g]), .frame_cnt(fc_w[g])
    );
  end

  // Model: phase = cycles since accept (-1 when idle), plus the frame bookkeeping.
  int m_phase[3], m_wr[3], m_fill[3], m_base[3], m_fc[3], m_coeff[3], m_rd[3];
  bit acc_seen[3];
  int n_cmp = 0, n_bad = 0, cyc = 0, mode = 0;

  int fidx[3], start[3], first_en[3], last_en[3], latch1[3], unm1[3], wr0[3];
  int unm_cur0 = 0, lat_cnt0 = 0, period0 = 0;
  int unm_frame[512];

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 2);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_cycle();
    cyc++;
    for (int i = 0; i < 3; i++) begin
      int p, l;
      logic e_ready, e_en, e_mask, e_latch;
      bit acc;
      logic [77:0] act_v, exp_v;
      l = lat_of(i);
      p = m_phase[i];
      acc = 1'b0;
      act_v = {ready_w[i], wr_en_w[i], wr_addr_w[i], wr_data_w[i], rd_w[i], coeff_w[i],
               clr_w[i], en_w[i], mask_w[i], latch_w[i], fc_w[i]};
      if (!resetn) begin
        exp_v = '0;
        m_phase[i] = -1; m_wr[i] = 0; m_fill[i] = 0; m_fc[i] = 0;
        m_coeff[i] = 0; m_rd[i] = 0; m_base[i] = 0;
      end else begin
        e_ready = (p < 0);
        acc = e_ready && valid_r[i];
        if (p >= 1 && p <= N) begin
          m_coeff[i] = p - 1;
          m_rd[i] = (m_base[i] - (p - 1)) & 255;
        end
        e_en = (p >= 1 + l) && (p <= N + l);
        e_mask = e_en && ((p - 1 - l) >= m_fill[i]);
        e_latch = (p == N + l + 1);
        exp_v = {e_ready, acc, 8'(m_wr[i]), data_r[i], 8'(m_rd[i]), 8'(m_coeff[i]),
                 acc, e_en, e_mask, e_latch, 16'(m_fc[i])};
        if (acc) begin
          m_base[i] = m_wr[i];
          m_wr[i] = (m_wr[i] + 1) % 256;
          m_fill[i] = (m_fill[i] < N) ? m_fill[i] + 1 : N;
          m_phase[i] = 1;
        end else if (p >= 0) begin
          if (e_latch) begin
            m_phase[i] = -1;
            m_fc[i] = (m_fc[i] + 1) % 65536;
          end else begin
            m_phase[i] = p + 1;
          end
        end
      end
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle %0d dut%0d outputs: got %h expected %h", cyc, i, act_v, exp_v);
      end
      acc_seen[i] = acc;

      // Observations used by the literal pins.
      if (!resetn) begin
        fidx[i] = 0;
        if (i == 0) begin unm_cur0 = 0; lat_cnt0 = 0; end
      end else begin
        if (clr_w[i]) begin
          fidx[i]++;
          if (i == 0 && fidx[0] == 3) period0 = cyc - start[0];
          start[i] = cyc;
          if (i == 0) unm_cur0 = 0;
          if (fidx[i] == 1) begin wr0[i] = int'(wr_addr_w[i]); first_en[i] = -1; unm1[i] = 0; end
        end
        if (en_w[i] && fidx[i] == 1) begin
          if (first_en[i] < 0) first_en[i] = cyc - start[i];
          last_en[i] = cyc - start[i];
          if (!mask_w[i]) unm1[i]++;
        end
        if (latch_w[i] && fidx[i] == 1) latch1[i] = cyc - start[i];
        if (i == 0) begin
          if (en_w[0] && !mask_w[0]) unm_cur0++;
          if (latch_w[0]) begin
            lat_cnt0++;
            if (lat_cnt0 < 512) unm_frame[lat_cnt0] = unm_cur0;
          end
        end
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      case (mode)
        0: if (acc_seen[i]) valid_r[i] = 1'b0;
        1: if (acc_seen[i] || !valid_r[i]) begin valid_r[i] = 1'b1; data_r[i] = $urandom; end
        default: begin
          if (acc_seen[i]) begin
            valid_r[i] = ($urandom_range(0, 1) == 1);
            data_r[i] = $urandom;
          end else if (!valid_r[i]) begin
            valid_r[i] = ($urandom_range(0, 3) == 0);
            data_r[i] = $urandom;
          end
        end
      endcase
    end
    if (mode == 2) resetn = ($urandom_range(0, 799) != 0);
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    drive();
  endtask

  int exp_first[3] = '{2, 1, 3};
  int exp_last[3]  = '{175, 174, 176};
  int exp_latch[3] = '{176, 175, 177};

  initial begin
    int k;
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_r[i] = 1'b0; data_r[i] = 32'd0; m_phase[i] = -1; fidx[i] = 0;
      first_en[i] = -1; last_en[i] = -1; latch1[i] = -1; unm1[i] = -1; wr0[i] = -1;
    end
    for (int f = 0; f < 512; f++) unm_frame[f] = -1;
    repeat (3) tick();
    chk("reset_ready", int'(ready_w[0]), 0);
    chk("reset_frame_cnt", int'(fc_w[2]), 0);

    // Single directed frame from reset.
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin valid_r[i] = 1'b1; data_r[i] = 32'h0000_1000; end
    mode = 0;
    repeat (200) tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("first_wr_addr_lat%0d", lat_of(i)), wr0[i], 0);
      chk($sformatf("acc_en_first_lat%0d", lat_of(i)), first_en[i], exp_first[i]);
      chk($sformatf("acc_en_last_lat%0d", lat_of(i)), last_en[i], exp_last[i]);
      chk($sformatf("latch_cycle_lat%0d", lat_of(i)), latch1[i], exp_latch[i]);
      chk($sformatf("frame1_unmasked_lat%0d", lat_of(i)), unm1[i], 1);
      chk($sformatf("frame_cnt_after1_lat%0d", lat_of(i)), int'(fc_w[i]), 1);
    end

    // Back-to-back frames with valid held high; crosses the 256-entry wrap.
    mode = 1;
    k = 0;
    while (lat_cnt0 < 301 && k < 56000) begin tick(); k++; end
    chk("hold_run_done", int'(lat_cnt0 >= 301), 1);
    chk("frame_period", period0, 177);
    chk("frame2_unmasked", unm_frame[2], 2);
    chk("frame5_unmasked", unm_frame[5], 5);
    chk("frame173_unmasked", unm_frame[173], 173);
    chk("frame174_unmasked", unm_frame[174], 174);
    chk("frame300_unmasked", unm_frame[300], 174);

    // One-cycle reset while tap 100 is being issued.
    k = 0;
    while (m_phase[0] != 101 && k < 400) begin tick(); k++; end
    chk("reach_tap100", int'(k < 400), 1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    k = 0;
    while (lat_cnt0 < 2 && k < 600) begin tick(); k++; end
    chk("post_reset_frames", lat_cnt0, 2);
    chk("post_reset_frame1_unmasked", unm_frame[1], 1);
    chk("post_reset_frame2_unmasked", unm_frame[2], 2);
    chk("post_reset_frame_cnt", int'(fc_w[0]), 2);

    // Random producer with occasional resets.
    mode = 2;
    repeat (3000) tick();
    resetn = 1'b1;
    mode = 0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
